// File: rtl/scan_mux_pkg.sv
// scan_mux_pkg: shared state encoding, mode constants and select-width helper for scan_mux
package scan_mux_pkg;
  typedef enum logic [1:0] {S_MANUAL, S_SCAN, S_HOLD} state_t;
  localparam logic MODE_MANUAL = 1'b0;
  localparam logic MODE_SCAN = 1'b1;
  function automatic int sel_width(input int c);
    return (c > 1) ? $clog2(c) : 1;
  endfunction
endpackage

// File: rtl/mux_core.sv
// mux_core: combinational channel picker
//   i_data     packed channels, channel k at [k*WIDTH +: WIDTH]
//   i_sel      channel index
//   o_data     selected word, zero when i_sel is out of range
//   o_in_range i_sel < CHANNELS
module mux_core
  import scan_mux_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter int CHANNELS = 7,
  localparam int SEL_W = sel_width(CHANNELS)
) (
  input  logic [CHANNELS*WIDTH-1:0] i_data,
  input  logic [SEL_W-1:0]          i_sel,
  output logic [WIDTH-1:0]          o_data,
  output logic                      o_in_range
);
  always_comb begin
    o_data = '0;
    for (int k = 0; k < CHANNELS; k++)
      if (i_sel == SEL_W'(k)) o_data = i_data[k*WIDTH +: WIDTH];
  end
  assign o_in_range = 32'(i_sel) < CHANNELS;
endmodule

// File: rtl/scan_mux.sv
// scan_mux: registered channel mux with manual select and dwell-timed auto-scan
//   Clock/Resetn  rising-edge clock, async active-low reset
//   Mode          0 manual (MuxSelect), 1 auto-scan
//   Hold          freezes scan position and dwell count while scanning
//   Dwell         extra cycles spent on each channel while scanning
//   Input         packed channel data
//   Out/Channel   registered selected word and its index (always paired)
//   Valid         Out comes from a legal channel
//   Wrap          one-cycle pulse when the scan returns to channel 0
module scan_mux
  import scan_mux_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter int CHANNELS = 7,
  parameter int DWELL_W = 4,
  localparam int SEL_W = sel_width(CHANNELS)
) (
  input  logic                      Clock,
  input  logic                      Resetn,
  input  logic                      Mode,
  input  logic [SEL_W-1:0]          MuxSelect,
  input  logic                      Hold,
  input  logic [DWELL_W-1:0]        Dwell,
  input  logic [CHANNELS*WIDTH-1:0] Input,
  output logic [WIDTH-1:0]          Out,
  output logic [SEL_W-1:0]          Channel,
  output logic                      Valid,
  output logic                      Wrap
);
  state_t               r_state, w_next_state;
  logic [SEL_W-1:0]     r_ch, w_next_ch;
  logic [DWELL_W-1:0]   r_cnt, w_next_cnt;
  logic [WIDTH-1:0]     r_out, w_word;
  logic                 r_valid, r_wrap, w_in_range;
  logic                 w_manual, w_entry, w_hold, w_adv, w_last;
  // Behaviour on each edge is chosen by the inputs seen at that edge, so
  // Mode=0 and Hold=1 take effect on the same edge they are sampled.
  always_comb begin
    w_manual     = Mode == MODE_MANUAL;
    w_entry      = !w_manual && r_state == S_MANUAL;
    w_hold       = !w_manual && !w_entry && Hold;
    w_adv        = !w_manual && !w_entry && !Hold && r_cnt >= Dwell;
    w_last       = r_ch == SEL_W'(CHANNELS - 1);
    w_next_state = w_manual ? S_MANUAL : w_hold ? S_HOLD : S_SCAN;
    w_next_ch    = w_manual ? MuxSelect :
                   w_entry  ? '0 :
                   w_adv    ? (w_last ? '0 : r_ch + SEL_W'(1)) : r_ch;
    w_next_cnt   = (w_manual || w_entry || w_adv) ? '0 :
                   w_hold   ? r_cnt : r_cnt + DWELL_W'(1);
  end
  mux_core #(.WIDTH(WIDTH), .CHANNELS(CHANNELS)) u_core (
    .i_data    (Input),
    .i_sel     (w_next_ch),
    .o_data    (w_word),
    .o_in_range(w_in_range)
  );
  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      r_state <= S_MANUAL;
      r_ch    <= '0;
      r_cnt   <= '0;
      r_out   <= '0;
      r_valid <= 1'b0;
      r_wrap  <= 1'b0;
    end else begin
      r_state <= w_next_state;
      r_ch    <= w_next_ch;
      r_cnt   <= w_next_cnt;
      r_out   <= w_word;
      r_valid <= w_in_range;
      r_wrap  <= w_adv && w_last;
    end
  end
  assign Out     = r_out;
  assign Channel = r_ch;
  assign Valid   = r_valid;
  assign Wrap    = r_wrap;
endmodule

// File: tb/tb_scan_mux.sv
// tb_scan_mux: directed self-checking bench for scan_mux (WIDTH=4, CHANNELS=7, DWELL_W=4)
module tb_scan_mux;
  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        mode = 1'b0;
  logic [2:0]  mux_sel = '0;
  logic        hold = 1'b0;
  logic [3:0]  dwell = '0;
  logic [3:0]  data [7];
  logic [27:0] in_bus;
  logic [3:0]  out;
  logic [2:0]  channel;
  logic        valid, wrap;
  int          checks = 0;
  int          errors = 0;

  for (genvar g = 0; g < 7; g++) begin : g_pack
    assign in_bus[g*4 +: 4] = data[g];
  end

  always #5 clk = ~clk;

  scan_mux #(.WIDTH(4), .CHANNELS(7), .DWELL_W(4)) dut (
    .Clock(clk), .Resetn(resetn), .Mode(mode), .MuxSelect(mux_sel), .Hold(hold),
    .Dwell(dwell), .Input(in_bus), .Out(out), .Channel(channel), .Valid(valid), .Wrap(wrap)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    #1;
    checks++; if (out !== 4'h0) begin errors++; $display("FAIL reset_out: got %0h expected 0", out); end
    checks++; if (channel !== 3'd0) begin errors++; $display("FAIL reset_channel: got %0d expected 0", channel); end
    checks++; if (valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %0b expected 0", valid); end
    checks++; if (wrap !== 1'b0) begin errors++; $display("FAIL reset_wrap: got %0b expected 0", wrap); end
    tick();
    checks++; if (valid !== 1'b0 || channel !== 3'd0) begin errors++; $display("FAIL reset_held: valid %0b ch %0d expected 0 0", valid, channel); end
    resetn = 1'b1;
  endtask

  task automatic test_manual();
    mode = 1'b0; hold = 1'b1; mux_sel = 3'd3;
    tick();
    checks++; if (out !== 4'hA) begin errors++; $display("FAIL manual_out: got %0h expected a", out); end
    checks++; if (channel !== 3'd3) begin errors++; $display("FAIL manual_channel: got %0d expected 3", channel); end
    checks++; if (valid !== 1'b1) begin errors++; $display("FAIL manual_valid: got %0b expected 1", valid); end
    checks++; if (wrap !== 1'b0) begin errors++; $display("FAIL manual_wrap: got %0b expected 0", wrap); end
    hold = 1'b0;
  endtask

  task automatic test_out_of_range();
    mux_sel = 3'd7;
    tick();
    checks++; if (out !== 4'h0) begin errors++; $display("FAIL oor_out: got %0h expected 0", out); end
    checks++; if (valid !== 1'b0) begin errors++; $display("FAIL oor_valid: got %0b expected 0", valid); end
    checks++; if (channel !== 3'd7) begin errors++; $display("FAIL oor_channel: got %0d expected 7", channel); end
  endtask

  task automatic test_scan_wrap();
    logic [2:0] exp_ch;
    mode = 1'b1; dwell = 4'd2;
    for (int i = 0; i <= 21; i++) begin
      tick();
      exp_ch = (i == 21) ? 3'd0 : 3'(i / 3);
      checks++; if (channel !== exp_ch) begin errors++; $display("FAIL scan_channel[%0d]: got %0d expected %0d", i, channel, exp_ch); end
      checks++; if (out !== data[exp_ch]) begin errors++; $display("FAIL scan_out[%0d]: got %0h expected %0h", i, out, data[exp_ch]); end
      checks++; if (wrap !== (i == 21)) begin errors++; $display("FAIL scan_wrap[%0d]: got %0b expected %0b", i, wrap, i == 21); end
      checks++; if (valid !== 1'b1) begin errors++; $display("FAIL scan_valid[%0d]: got %0b expected 1", i, valid); end
    end
  endtask

  task automatic test_hold();
    repeat (13) tick();
    checks++; if (channel !== 3'd4) begin errors++; $display("FAIL hold_start: got %0d expected 4", channel); end
    hold = 1'b1;
    for (int i = 0; i < 5; i++) begin
      data[4] = 4'hB + 4'(i);
      tick();
      checks++; if (channel !== 3'd4) begin errors++; $display("FAIL hold_channel[%0d]: got %0d expected 4", i, channel); end
      checks++; if (out !== 4'hB + 4'(i)) begin errors++; $display("FAIL hold_out[%0d]: got %0h expected %0h", i, out, 4'hB + 4'(i)); end
    end
    hold = 1'b0;
    tick();
    checks++; if (channel !== 3'd4 || out !== 4'hF) begin errors++; $display("FAIL hold_resume: ch %0d out %0h expected 4 f", channel, out); end
    tick();
    checks++; if (channel !== 3'd5 || out !== 4'h6) begin errors++; $display("FAIL hold_advance: ch %0d out %0h expected 5 6", channel, out); end
    data[4] = 4'h5;
  endtask

  task automatic test_dwell_change();
    dwell = 4'd8;
    repeat (5) tick();
    checks++; if (channel !== 3'd5) begin errors++; $display("FAIL dwell_long: got %0d expected 5", channel); end
    dwell = 4'd2;
    tick();
    checks++; if (channel !== 3'd6 || out !== 4'h7) begin errors++; $display("FAIL dwell_lowered: ch %0d out %0h expected 6 7", channel, out); end
  endtask

  task automatic test_async_reset();
    repeat (18) tick();
    checks++; if (channel !== 3'd5) begin errors++; $display("FAIL areset_pre: got %0d expected 5", channel); end
    #3 resetn = 1'b0;
    #1;
    checks++; if (out !== 4'h0) begin errors++; $display("FAIL areset_out: got %0h expected 0", out); end
    checks++; if (channel !== 3'd0) begin errors++; $display("FAIL areset_channel: got %0d expected 0", channel); end
    checks++; if (valid !== 1'b0 || wrap !== 1'b0) begin errors++; $display("FAIL areset_flags: valid %0b wrap %0b expected 0 0", valid, wrap); end
    #2 resetn = 1'b1;
    tick();
    checks++; if (channel !== 3'd0 || out !== 4'h1 || valid !== 1'b1) begin errors++; $display("FAIL restart: ch %0d out %0h valid %0b expected 0 1 1", channel, out, valid); end
    repeat (2) tick();
    checks++; if (channel !== 3'd0) begin errors++; $display("FAIL restart_dwell: got %0d expected 0", channel); end
    tick();
    checks++; if (channel !== 3'd1 || out !== 4'h2) begin errors++; $display("FAIL restart_advance: ch %0d out %0h expected 1 2", channel, out); end
  endtask

  initial begin
    data[0] = 4'h1; data[1] = 4'h2; data[2] = 4'h3; data[3] = 4'hA;
    data[4] = 4'h5; data[5] = 4'h6; data[6] = 4'h7;
    test_reset();
    test_manual();
    test_out_of_range();
    test_scan_wrap();
    test_hold();
    test_dwell_change();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/scan_mux.md
SCAN_MUX -- requirements
Module: scan_mux

Interface
REQ-001 SHALL have parameter WIDTH, 4, bit width of each channel.
REQ-002 SHALL have parameter CHANNELS, 7, number of input channels (2..16).
REQ-003 SHALL have parameter DWELL_W, 4, width of the dwell-count input.
REQ-004 SHALL derive local constant SEL_W = clog2(CHANNELS), min 1.
REQ-005 SHALL have one clock and an asynchronous, active-low reset.
REQ-006 Port Clock  input  1  rising-edge clock.
REQ-007 Port Resetn  input  1  asynchronous active-low reset.
REQ-008 Port Mode  input  1  0 = manual select, 1 = auto-scan.
REQ-009 Port MuxSelect  input  SEL_W  channel index used in manual mode.
REQ-010 Port Hold  input  1  freezes the scan position (scan mode only).
REQ-011 Port Dwell  input  DWELL_W  extra cycles spent on each channel in scan mode.
REQ-012 Port Input  input  CHANNELS*WIDTH  packed channels, channel k at bits [k*WIDTH +: WIDTH].
REQ-013 Port Out  output  WIDTH  registered selected data.
REQ-014 Port Channel  output  SEL_W  index of the channel currently driving Out.
REQ-015 Port Valid  output  1  Out holds a legal channel's data.
REQ-016 Port Wrap  output  1  one-cycle pulse on scan wrap-around.

Function
REQ-017 SHALL implement FSM states S_MANUAL, S_SCAN, S_HOLD; state is registered.
REQ-018 Transitions: Mode=0 -> S_MANUAL from any state (priority over Hold); Mode=1 & Hold=0 -> S_SCAN; Mode=1 & Hold=1 from S_SCAN or S_HOLD -> S_HOLD.
REQ-019 On every edge, Channel <= next_ch and Out <= Input[next_ch] in the same edge, so Out and Channel always correspond; latency is 1 cycle from select to Out.
REQ-020 S_MANUAL: next_ch = MuxSelect. Valid <= 1 if MuxSelect < CHANNELS. Otherwise Out <= 0, Valid <= 0, and Channel <= MuxSelect. No X is ever driven.
REQ-021 Entering scan from S_MANUAL (first edge with Mode=1): next_ch = 0, dwell counter <= 0, Hold ignored on that edge.
REQ-022 S_SCAN: the dwell counter increments each cycle. When counter >= Dwell, next_ch = Channel+1 and counter <= 0. Dwell=0 advances every cycle, so each channel is held Dwell+1 cycles.
REQ-023 A Dwell change mid-count SHALL take effect immediately via the >= compare; lowering Dwell below the counter forces an advance on the next edge.
REQ-024 Wrap: when the advance is from CHANNELS-1, next_ch = 0 and Wrap <= 1 for exactly one cycle; otherwise Wrap <= 0.
REQ-025 S_HOLD: Channel and the dwell counter are frozen, and Out is re-sampled from Input[Channel] every edge. Leaving S_HOLD resumes counting from the frozen count.
REQ-026 In scan/hold, Valid <= 1, because Channel is always < CHANNELS.

Reset
REQ-027 Resetn=0 SHALL asynchronously force Out=0, Channel=0, Valid=0, Wrap=0, dwell counter=0, state=S_MANUAL, without waiting for a clock edge.
REQ-028 Reset mid-scan SHALL discard scan position; after release, behaviour follows REQ-020/REQ-021 from the first rising edge.

Structure
REQ-029 Package scan_mux_pkg SHALL hold the state typedef (S_MANUAL, S_SCAN, S_HOLD) and the mode constants MODE_MANUAL=0, MODE_SCAN=1.
REQ-030 SHALL instantiate one combinational sub-module mux_core (parameters WIDTH, CHANNELS), which returns the selected word plus an in-range flag. All registers live in scan_mux.

Verification (WIDTH=4, CHANNELS=7, DWELL_W=4)
REQ-031 Manual select: Mode=0, MuxSelect=3, channel 3 = 4'hA -> after 1 edge Out=4'hA, Channel=3, Valid=1.
REQ-032 Out-of-range select: Mode=0, MuxSelect=7 -> after 1 edge Out=4'h0, Valid=0, Channel=7.
REQ-033 Scan with dwell: Mode=1, Dwell=2 -> Channel steps 0,1,...,6, each for 3 cycles. Wrap=1 only in the cycle Channel returns to 0 (21 cycles after entry).
REQ-034 Hold in scan: Hold=1 for 5 cycles at Channel=4, changing channel 4 data each cycle -> Channel stays 4 and Out tracks the data with 1-cycle latency. After Hold=0, the remaining dwell cycles complete before advancing to 5.
REQ-035 Dwell change mid-count: Dwell=8 with counter at 5, Dwell set to 2 -> advance on the next edge.
REQ-036 Async reset mid-scan: Resetn=0 between clock edges at Channel=5 -> Out=0, Channel=0, Valid=0 immediately. After release with Mode=1 -> scan restarts at channel 0.
